omsp_spm_cmd_seq: RTL and testbench
===================================

// Module: omsp_spm_cmd_seq
// PURPOSE
//  Sequences SPM configuration commands (protect, unprotect, query) into the SPM control block.
//  Arbitrates between two requesters: CPU execution unit (req 0) and debug unit (req 1).
//  Drives update_spm/enable_spm/data_request, samples violation/select results, and returns
//  one completion pulse with status and data. Sits between the requesters and omsp_spm_control.
// PARAMETERS
//  SETTLE   1  cycles held in WAIT after ISSUE before sampling SPM results (1..7)
//  RR       1  1 = round-robin arbitration, 0 = fixed priority (CPU over debug)
// PORTS
//  mclk              in   1   system clock
//  puc_rst           in   1   synchronous active-high reset
//  cpu_req           in   1   CPU command request, level, held until cmd_done with cmd_id=0
//  cpu_op            in   4   [3:2] op: 00 protect, 01 unprotect, 10 query, 11 illegal; [1:0] query sel
//  dbg_req           in   1   debug command request, same rules as cpu_req
//  dbg_op            in   4   debug op, same encoding as cpu_op
//  spm_free          in   1   at least one SPM slot disabled
//  violation         in   1   SPM array violation
//  spm_select_valid  in   1   query hit an enabled SPM
//  requested_data    in   16  query result from SPM array
//  update_spm        out  1   one-cycle update strobe to SPM control
//  enable_spm        out  1   1 = create SPM, 0 = destroy; meaningful only with update_spm
//  data_request      out  2   query selector to SPM array
//  busy              out  1   sequencer not IDLE (stalls CPU)
//  cmd_done          out  1   one-cycle completion pulse
//  cmd_id            out  1   requester owning completed command (0 CPU, 1 debug)
//  cmd_ok            out  1   command succeeded
//  cmd_data          out  16  query result; 0 for non-query or failed commands
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; last_grant = 1 (CPU wins first tie).
//  All outputs registered. FSM: IDLE -> ISSUE -> WAIT (SETTLE cycles) -> DONE -> IDLE.
//  IDLE: if any req sampled high at edge k, latch winner id and op; ISSUE during cycle k+1.
//  Arbitration: one req -> it wins. Both: RR=1 -> grant != last_grant; RR=0 -> CPU. last_grant updates at grant.
//  ISSUE (1 cycle): protect with spm_free=1 -> update_spm=1, enable_spm=1.
//   unprotect -> update_spm=1, enable_spm=0. query -> data_request=sel, no update.
//   protect with spm_free=0 or op=11 -> no SPM activity; skip WAIT, go DONE with cmd_ok=0.
//  WAIT: update_spm=0; query keeps data_request=sel. Results sampled in last WAIT cycle:
//   protect: ok = ~violation. unprotect: ok = 1. query: ok = spm_select_valid, data = ok ? requested_data : 0.
//  DONE: cmd_done=1 for exactly one cycle with cmd_id/cmd_ok/cmd_data; data_request returns to 0.
//  Latency (normal): req at edge k -> update/query at k+1 -> cmd_done at cycle k+2+SETTLE.
//  Fast-fail latency: cmd_done at cycle k+2.
//  busy = 1 from ISSUE through DONE inclusive.
//  cmd_id/cmd_ok/cmd_data hold last values after DONE until next DONE.
//  Requests are not sampled in DONE; a req still high is re-arbitrated in the following IDLE cycle.
//  Requester must drop req on its cmd_done cycle or it is treated as a new command.
//  Req deasserted mid-command: command still completes and cmd_done still pulses.
//  op changes after grant: ignored, the latched op is used.
//  puc_rst mid-command: FSM to IDLE next edge; no further update_spm; no cmd_done for aborted command.
//  update_spm never asserted for more than one consecutive cycle; never with puc_rst high.
// TESTING
//  Reset: puc_rst=1 for 3 cycles with both reqs high -> all outputs 0, no update_spm.
//  CPU protect, spm_free=1, violation=0, SETTLE=1: req at k -> update_spm=1,enable_spm=1 at k+1, cmd_done,id=0,ok=1 at k+3.
//  Protect with violation=1 in WAIT -> cmd_ok=0, cmd_data=0; protect with spm_free=0 -> no update, cmd_done,ok=0 at k+2.
//  Debug query sel=2'b10, spm_select_valid=1, requested_data=16'hA5C3 -> data_request=2'b10 in ISSUE/WAIT, cmd_done,id=1,ok=1,data=16'hA5C3.
//  Both reqs held, RR=1 -> completions ordered CPU, debug, CPU, debug; RR=0 -> CPU only while cpu_req held.
//  Reset in WAIT after update_spm -> no cmd_done, busy=0 next cycle; illegal op 11 -> cmd_done,ok=0, no update.

Source files
------------

// File: rtl/omsp_spm_cmd_seq.sv
// SPM command sequencer: arbitrates CPU/debug requests, issues protect/unprotect/query
// commands to the SPM control block and returns one completion pulse with status and data.
module omsp_spm_cmd_seq #(
    parameter int unsigned SETTLE = 1,  // WAIT cycles before sampling SPM results (1..7)
    parameter int unsigned RR     = 1   // 1 = round-robin, 0 = fixed priority (CPU first)
) (
    input  logic        mclk,
    input  logic        puc_rst,
    input  logic        cpu_req,
    input  logic [3:0]  cpu_op,
    input  logic        dbg_req,
    input  logic [3:0]  dbg_op,
    input  logic        spm_free,
    input  logic        violation,
    input  logic        spm_select_valid,
    input  logic [15:0] requested_data,
    output logic        update_spm,
    output logic        enable_spm,
    output logic [1:0]  data_request,
    output logic        busy,
    output logic        cmd_done,
    output logic        cmd_id,
    output logic        cmd_ok,
    output logic [15:0] cmd_data
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_t;

    localparam logic [1:0] OpProtect   = 2'b00;
    localparam logic [1:0] OpUnprotect = 2'b01;
    localparam logic [1:0] OpQuery     = 2'b10;
    localparam logic [2:0] LastWait    = 3'(SETTLE - 1);

    state_t      state;
    logic        last_grant;
    logic        cur_id;
    logic [3:0]  cur_op;
    logic        fast_fail;
    logic [2:0]  wait_cnt;

    logic        any_req;
    logic        grant_id;
    logic [3:0]  win_op;
    logic        win_fail;

    // Arbitration and fast-fail decision for the request sampled this edge
    always_comb begin
        any_req = cpu_req | dbg_req;
        if (cpu_req && dbg_req) begin
            grant_id = (RR != 0) ? ~last_grant : 1'b0;
        end else begin
            grant_id = ~cpu_req;
        end
        win_op   = grant_id ? dbg_op : cpu_op;
        win_fail = (win_op[3:2] == 2'b11) || ((win_op[3:2] == OpProtect) && !spm_free);
    end

    // Command FSM with registered outputs
    always_ff @(posedge mclk) begin
        if (puc_rst) begin
            state        <= StIdle;
            last_grant   <= 1'b1;
            cur_id       <= 1'b0;
            cur_op       <= 4'd0;
            fast_fail    <= 1'b0;
            wait_cnt     <= 3'd0;
            update_spm   <= 1'b0;
            enable_spm   <= 1'b0;
            data_request <= 2'b00;
            busy         <= 1'b0;
            cmd_done     <= 1'b0;
            cmd_id       <= 1'b0;
            cmd_ok       <= 1'b0;
            cmd_data     <= 16'd0;
        end else begin
            case (state)
                StIdle: begin
                    if (any_req) begin
                        state      <= StIssue;
                        busy       <= 1'b1;
                        cur_id     <= grant_id;
                        cur_op     <= win_op;
                        last_grant <= grant_id;
                        fast_fail  <= win_fail;
                        case (win_op[3:2])
                            OpProtect: begin
                                update_spm <= spm_free;
                                enable_spm <= spm_free;
                            end
                            OpUnprotect: begin
                                update_spm <= 1'b1;
                                enable_spm <= 1'b0;
                            end
                            OpQuery: data_request <= win_op[1:0];
                            default: ;
                        endcase
                    end
                end
                StIssue: begin
                    update_spm <= 1'b0;
                    enable_spm <= 1'b0;
                    wait_cnt   <= 3'd0;
                    if (fast_fail) begin
                        state    <= StDone;
                        cmd_done <= 1'b1;
                        cmd_id   <= cur_id;
                        cmd_ok   <= 1'b0;
                        cmd_data <= 16'd0;
                    end else begin
                        state <= StWait;
                    end
                end
                StWait: begin
                    if (wait_cnt == LastWait) begin
                        state        <= StDone;
                        cmd_done     <= 1'b1;
                        cmd_id       <= cur_id;
                        data_request <= 2'b00;
                        cmd_data     <= 16'd0;
                        case (cur_op[3:2])
                            OpProtect:   cmd_ok <= ~violation;
                            OpUnprotect: cmd_ok <= 1'b1;
                            OpQuery: begin
                                cmd_ok   <= spm_select_valid;
                                cmd_data <= spm_select_valid ? requested_data : 16'd0;
                            end
                            default:     cmd_ok <= 1'b0;
                        endcase
                    end else begin
                        wait_cnt <= wait_cnt + 3'd1;
                    end
                end
                StDone: begin
                    // Requests are not sampled here; a held req is re-arbitrated in IDLE
                    cmd_done <= 1'b0;
                    busy     <= 1'b0;
                    state    <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_omsp_spm_cmd_seq.sv
// Self-checking bench for omsp_spm_cmd_seq (SETTLE=1, round-robin and fixed-priority instances).
module tb_omsp_spm_cmd_seq;

    logic        mclk = 1'b0;
    logic        puc_rst;
    logic        cpu_req, dbg_req;
    logic [3:0]  cpu_op, dbg_op;
    logic        spm_free, violation, spm_select_valid;
    logic [15:0] requested_data;

    logic        update_spm, enable_spm, busy, cmd_done, cmd_id, cmd_ok;
    logic [1:0]  data_request;
    logic [15:0] cmd_data;

    logic        fp_update_spm, fp_enable_spm, fp_busy, fp_cmd_done, fp_cmd_id, fp_cmd_ok;
    logic [1:0]  fp_data_request;
    logic [15:0] fp_cmd_data;

    int tests = 0;
    int fails = 0;

    always #5 mclk = ~mclk;

    omsp_spm_cmd_seq #(.SETTLE(1), .RR(1)) dut (
        .mclk(mclk), .puc_rst(puc_rst),
        .cpu_req(cpu_req), .cpu_op(cpu_op), .dbg_req(dbg_req), .dbg_op(dbg_op),
        .spm_free(spm_free), .violation(violation), .spm_select_valid(spm_select_valid),
        .requested_data(requested_data),
        .update_spm(update_spm), .enable_spm(enable_spm), .data_request(data_request),
        .busy(busy), .cmd_done(cmd_done), .cmd_id(cmd_id), .cmd_ok(cmd_ok), .cmd_data(cmd_data)
    );

    omsp_spm_cmd_seq #(.SETTLE(1), .RR(0)) dut_fp (
        .mclk(mclk), .puc_rst(puc_rst),
        .cpu_req(cpu_req), .cpu_op(cpu_op), .dbg_req(dbg_req), .dbg_op(dbg_op),
        .spm_free(spm_free), .violation(violation), .spm_select_valid(spm_select_valid),
        .requested_data(requested_data),
        .update_spm(fp_update_spm), .enable_spm(fp_enable_spm), .data_request(fp_data_request),
        .busy(fp_busy), .cmd_done(fp_cmd_done), .cmd_id(fp_cmd_id), .cmd_ok(fp_cmd_ok),
        .cmd_data(fp_cmd_data)
    );

    typedef struct {
        string       name;
        bit          id;      // requester
        logic [3:0]  op;
        bit          free;
        bit          viol;
        bit          ssv;
        logic [15:0] rdata;
        bit          drop;    // drop req and scramble op right after grant
        bit          e_upd;
        bit          e_en;
        logic [1:0]  e_dr;
        int          e_lat;   // cycles from grant edge to cmd_done cycle
        bit          e_ok;
        logic [15:0] e_data;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drop_reqs();
        cpu_req = 1'b0;
        dbg_req = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int  n = 0;
        bit  seen = 0;
        int  upd_extra = 0;
        spm_free         = v.free;
        violation        = v.viol;
        spm_select_valid = v.ssv;
        requested_data   = v.rdata;
        if (v.id) begin dbg_req = 1'b1; dbg_op = v.op; end
        else      begin cpu_req = 1'b1; cpu_op = v.op; end
        while (!seen && n < 20) begin
            @(negedge mclk);
            n++;
            if (n == 1) begin
                chk({v.name, "/issue_update"}, 32'(update_spm), 32'(v.e_upd));
                if (v.e_upd) chk({v.name, "/issue_enable"}, 32'(enable_spm), 32'(v.e_en));
                chk({v.name, "/issue_dreq"}, 32'(data_request), 32'(v.e_dr));
                chk({v.name, "/issue_busy"}, 32'(busy), 32'd1);
                if (v.drop) begin
                    drop_reqs();
                    cpu_op = 4'b1100;
                    dbg_op = 4'b1100;
                end
            end else if (update_spm) begin
                upd_extra++;
            end
            if (n == 2 && v.e_lat == 3)
                chk({v.name, "/wait_dreq"}, 32'(data_request), 32'(v.e_dr));
            if (cmd_done) begin
                seen = 1;
                chk({v.name, "/latency"}, 32'(n), 32'(v.e_lat));
                chk({v.name, "/cmd_id"}, 32'(cmd_id), 32'(v.id));
                chk({v.name, "/cmd_ok"}, 32'(cmd_ok), 32'(v.e_ok));
                chk({v.name, "/cmd_data"}, 32'(cmd_data), 32'(v.e_data));
                chk({v.name, "/done_dreq"}, 32'(data_request), 32'd0);
                chk({v.name, "/done_busy"}, 32'(busy), 32'd1);
                drop_reqs();
            end
        end
        if (!seen) chk({v.name, "/done_timeout"}, 32'd0, 32'd1);
        @(negedge mclk);
        chk({v.name, "/done_pulse_len"}, 32'(cmd_done), 32'd0);
        chk({v.name, "/idle_busy"}, 32'(busy), 32'd0);
        chk({v.name, "/hold_data"}, 32'(cmd_data), 32'(v.e_data));
        chk({v.name, "/no_extra_update"}, 32'(upd_extra), 32'd0);
    endtask

    initial begin
        int rr_ids[$];
        int fp_ids[$];
        bit prev_upd;
        int upd_twice;
        bit bad;

        //                name         id op      free viol ssv rdata     drop upd en dr    lat ok data
        vecs[0] = '{"prot_ok",    0, 4'b0000, 1, 0, 0, 16'h0000, 0, 1, 1, 2'b00, 3, 1, 16'h0000};
        vecs[1] = '{"prot_viol",  0, 4'b0000, 1, 1, 1, 16'hFFFF, 0, 1, 1, 2'b00, 3, 0, 16'h0000};
        vecs[2] = '{"prot_full",  0, 4'b0001, 0, 0, 0, 16'h0000, 0, 0, 0, 2'b00, 2, 0, 16'h0000};
        vecs[3] = '{"dbg_query",  1, 4'b1010, 1, 0, 1, 16'hA5C3, 0, 0, 0, 2'b10, 3, 1, 16'hA5C3};
        vecs[4] = '{"query_miss", 1, 4'b1001, 1, 0, 0, 16'h1234, 0, 0, 0, 2'b01, 3, 0, 16'h0000};
        vecs[5] = '{"unprot_drop",0, 4'b0100, 0, 1, 0, 16'h0000, 1, 1, 0, 2'b00, 3, 1, 16'h0000};
        vecs[6] = '{"dbg_illegal",1, 4'b1111, 1, 0, 1, 16'h5555, 0, 0, 0, 2'b00, 2, 0, 16'h0000};
        vecs[7] = '{"cpu_query",  0, 4'b1011, 1, 1, 1, 16'hBEEF, 0, 0, 0, 2'b11, 3, 1, 16'hBEEF};

        // Reset held 3 cycles with both requests high
        puc_rst = 1'b1;
        cpu_req = 1'b1; cpu_op = 4'b0000;
        dbg_req = 1'b1; dbg_op = 4'b0000;
        spm_free = 1'b1; violation = 1'b0; spm_select_valid = 1'b0; requested_data = 16'h0;
        for (int c = 0; c < 3; c++) begin
            @(negedge mclk);
            chk("rst_outputs", {update_spm, enable_spm, data_request, busy, cmd_done, cmd_id,
                                cmd_ok, cmd_data}, 32'd0);
            chk("rst_fp_update", 32'(fp_update_spm), 32'd0);
        end

        // Both requests held: round-robin alternates, fixed priority keeps CPU
        puc_rst = 1'b0;
        prev_upd = 1'b0;
        upd_twice = 0;
        for (int c = 0; c < 40 && (rr_ids.size() < 4 || fp_ids.size() < 4); c++) begin
            @(negedge mclk);
            if (update_spm && prev_upd) upd_twice++;
            prev_upd = update_spm;
            if (cmd_done && rr_ids.size() < 4) rr_ids.push_back(int'(cmd_id));
            if (fp_cmd_done && fp_ids.size() < 4) fp_ids.push_back(int'(fp_cmd_id));
        end
        drop_reqs();
        chk("rr_count", 32'(rr_ids.size()), 32'd4);
        chk("fp_count", 32'(fp_ids.size()), 32'd4);
        for (int i = 0; i < rr_ids.size(); i++) chk($sformatf("rr_order%0d", i), 32'(rr_ids[i]), 32'(i % 2));
        for (int i = 0; i < fp_ids.size(); i++) chk($sformatf("fp_order%0d", i), 32'(fp_ids[i]), 32'd0);
        chk("update_single_cycle", 32'(upd_twice), 32'd0);

        // Clean restart before the vector table
        puc_rst = 1'b1;
        @(negedge mclk);
        puc_rst = 1'b0;
        @(negedge mclk);

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Reset in WAIT after the update strobe aborts the command
        spm_free = 1'b1; violation = 1'b0;
        cpu_req = 1'b1; cpu_op = 4'b0000;
        @(negedge mclk);
        chk("abort/issue_update", 32'(update_spm), 32'd1);
        @(negedge mclk);
        chk("abort/in_wait_busy", 32'(busy), 32'd1);
        puc_rst = 1'b1;
        cpu_req = 1'b0;
        @(negedge mclk);
        chk("abort/busy", 32'(busy), 32'd0);
        chk("abort/cmd_done", 32'(cmd_done), 32'd0);
        chk("abort/update", 32'(update_spm), 32'd0);
        puc_rst = 1'b0;
        bad = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge mclk);
            if (cmd_done || update_spm || busy) bad = 1'b1;
        end
        chk("abort/quiet_after", 32'(bad), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
